sar_sample_buffer: RTL and testbench
====================================

SAR_SAMPLE_BUFFER -- requirements
Module: sar_sample_buffer

Interface
REQ-001 Parameter SAMPLE_W, default 8: width of one conversion result.
REQ-002 Parameter DEPTH, default 8: FIFO entries, power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 eoc  input  1  end-of-conversion strobe from the SAR logic stage.
REQ-006 data  input  SAMPLE_W  conversion result from the SAR logic stage, valid while eoc is high.
REQ-007 rd_ready  input  1  consumer accepts rd_data this cycle.
REQ-008 clr_ovf  input  1  clears the sticky overflow flag.
REQ-009 rd_valid  output  1  rd_data holds the oldest stored sample.
REQ-010 rd_data  output  SAMPLE_W  oldest stored sample (first-word fall-through).
REQ-011 level  output  log2(DEPTH)+1  number of stored samples, 0..DEPTH.
REQ-012 full  output  1  level == DEPTH.
REQ-013 empty  output  1  level == 0.
REQ-014 overflow  output  1  sticky: a sample was dropped because the FIFO was full.
REQ-015 sample_cnt  output  16  count of samples accepted since reset, wraps 0xFFFF -> 0x0000.

Function
REQ-016 Capture: a write request is generated only on the rising edge of eoc (eoc high this cycle, low the previous cycle); eoc held high generates exactly one write.
REQ-017 On a write request, data is written into the FIFO at the same posedge where eoc is first sampled high.
REQ-018 Write-to-read latency: rd_valid rises on the cycle after the write edge into an empty FIFO; there is no combinational bypass from data to rd_data.
REQ-019 A read occurs at a posedge where rd_valid && rd_ready; rd_data then advances to the next entry, or rd_valid falls if none remains.
REQ-020 rd_ready while rd_valid is low has no effect and does not change level.
REQ-021 rd_data remains stable while rd_valid is high and rd_ready is low.
REQ-022 Write only: level +1. Read only: level -1. Simultaneous write and read: level unchanged and both are performed.
REQ-023 Full with simultaneous read and write: the write is accepted, overflow is not set, and level stays DEPTH.
REQ-024 Full with write and no read: the sample is dropped, overflow is set at that edge, level and the stored contents are unchanged, and sample_cnt does not increment.
REQ-025 overflow clears on a posedge with clr_ovf high; if a drop coincides with clr_ovf, overflow ends up set.
REQ-026 sample_cnt increments by 1 for each accepted write only.
REQ-027 Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH; full/empty are derived from level, not from pointer equality.
REQ-028 full, empty and level are registered and consistent with each other every cycle.

Reset
REQ-029 While reset is high: rd_valid=0, empty=1, full=0, level=0, overflow=0, sample_cnt=0, pointers=0, previous-eoc register=0, rd_data=0.
REQ-030 Reset asserted mid-operation discards all stored samples immediately; storage array contents need not be cleared.
REQ-031 After reset deasserts with eoc already high, a write occurs on the first edge (previous-eoc is 0).

Structure
REQ-032 Shared package sar_pkg holds SAMPLE_W default, DEPTH default, and the derived pointer and level width constants used by the SAR logic stage and this block.
REQ-033 One sub-module, sar_fifo_core, holds the storage, pointers and level; the top holds the eoc edge detect, overflow and sample_cnt.

Verification
REQ-034 Reset, then eoc pulses with data 0x80, 0x3C, 0xFF, rd_ready=1 -> rd_data 0x80, 0x3C, 0xFF, each valid the cycle after its eoc; sample_cnt=3.
REQ-035 eoc held high 5 cycles with data 0x55 -> exactly one entry; level=1; sample_cnt=1.
REQ-036 rd_ready=0, 9 eoc pulses with data 0x01..0x09 -> full=1 after the 8th pulse; the 9th pulse sets overflow; reads return 0x01..0x08; sample_cnt=8.
REQ-037 Full, eoc pulse (0xA5) and read in the same cycle -> overflow stays 0, level=8, 0xA5 is read last.
REQ-038 Drop coincident with clr_ovf -> overflow=1; clr_ovf alone on the next cycle -> overflow=0.
REQ-039 Reset asserted with level=5 -> level=0, rd_valid=0 asynchronously; the next eoc pulse (0x12) is read as the first entry.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared constants for the SAR conversion path: default sample width/depth and
// derived pointer/level widths used by the logic stage and the sample buffer.
package sar_pkg;
  localparam int SAMPLE_W_DEF = 8;
  localparam int DEPTH_DEF    = 8;

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  localparam int PTR_W_DEF = ptr_w(DEPTH_DEF);
  localparam int LVL_W_DEF = PTR_W_DEF + 1;
endpackage

// File: rtl/sar_fifo_core.sv
// First-word fall-through sample store: storage, wrapping pointers and a
// registered level from which full/empty are derived.
module sar_fifo_core
  import sar_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int DEPTH    = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [SAMPLE_W-1:0]       wr_data,
  input  logic                      rd_en,
  output logic                      wr_ok,
  output logic                      rd_valid,
  output logic [SAMPLE_W-1:0]       rd_data,
  output logic [ptr_w(DEPTH):0]     level,
  output logic                      full,
  output logic                      empty
);
  localparam int PW = ptr_w(DEPTH);
  localparam int LW = PW + 1;

  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       level_nxt;
  logic                rd_fire;

  assign rd_fire  = rd_en && !empty;
  // A full buffer still takes a write when the head is leaving in the same cycle.
  assign wr_ok    = wr_en && (!full || rd_fire);
  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    case ({wr_ok, rd_fire})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok)   wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      full  <= (level_nxt == LW'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end
endmodule

// File: rtl/sar_sample_buffer.sv
// Buffers SAR conversion results: one write per eoc rising edge, sticky
// overflow on dropped samples, and a wrapping count of accepted samples.
module sar_sample_buffer
  import sar_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int DEPTH    = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  eoc,
  input  logic [SAMPLE_W-1:0]   data,
  input  logic                  rd_ready,
  input  logic                  clr_ovf,
  output logic                  rd_valid,
  output logic [SAMPLE_W-1:0]   rd_data,
  output logic [ptr_w(DEPTH):0] level,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic [15:0]           sample_cnt
);
  logic eoc_q, wr_req, wr_ok, drop;

  assign wr_req = eoc && !eoc_q;
  assign drop   = wr_req && !wr_ok;

  sar_fifo_core #(.SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH)) u_core (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_req),
    .wr_data (data),
    .rd_en   (rd_ready),
    .wr_ok   (wr_ok),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  // A drop wins over a same-cycle clear so the loss is never hidden.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eoc_q      <= 1'b0;
      overflow   <= 1'b0;
      sample_cnt <= '0;
    end else begin
      eoc_q <= eoc;
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      if (wr_ok) sample_cnt <= sample_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_sar_sample_buffer.sv
// Randomized and directed bench for sar_sample_buffer with a queue-based
// reference model and a decoupled read-side monitor.
module tb_sar_sample_buffer;
  localparam int SW    = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset, eoc, rd_ready, clr_ovf;
  logic [SW-1:0] data;
  logic          rd_valid, full, empty, overflow;
  logic [SW-1:0] rd_data;
  logic [3:0]    level;
  logic [15:0]   sample_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [SW-1:0] sb[$];
  int            m_level;
  bit            m_prev, m_ovf;
  logic [15:0]   m_cnt;

  sar_sample_buffer #(.SAMPLE_W(SW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .eoc(eoc), .data(data), .rd_ready(rd_ready),
    .clr_ovf(clr_ovf), .rd_valid(rd_valid), .rd_data(rd_data), .level(level),
    .full(full), .empty(empty), .overflow(overflow), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sb.delete();
      m_level = 0; m_prev = 0; m_ovf = 0; m_cnt = '0;
    end else begin
      bit rd, rise, acc;
      rd   = (m_level > 0) && rd_ready;
      rise = eoc && !m_prev;
      m_prev = eoc;
      acc  = 0;
      if (rise && (m_level < DEPTH || rd)) begin
        sb.push_back(data);
        m_cnt = m_cnt + 16'd1;
        acc = 1;
      end
      if (rise && !acc) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      m_level = m_level + int'(acc) - int'(rd);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("level",      32'(level),      32'(m_level));
      chk("full",       32'(full),       32'(m_level == DEPTH));
      chk("empty",      32'(empty),      32'(m_level == 0));
      chk("rd_valid",   32'(rd_valid),   32'(m_level > 0));
      chk("overflow",   32'(overflow),   32'(m_ovf));
      chk("sample_cnt", 32'(sample_cnt), 32'(m_cnt));
      if (rd_valid) begin
        if (sb.size() == 0) chk("sb_underrun", 32'(rd_valid), 32'd0);
        else begin
          chk("rd_data", 32'(rd_data), 32'(sb[0]));
          if (rd_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic pulse(input logic [SW-1:0] d);
    eoc = 1'b1; data = d; tick();
    eoc = 1'b0; tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; eoc = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0; data = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, limit 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; eoc = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0; data = '0;
    #1;
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_level",    32'(level),    32'd0);
    chk("rst_ovf",      32'(overflow), 32'd0);
    chk("rst_cnt",      32'(sample_cnt), 32'd0);
    chk("rst_rd_data",  32'(rd_data),  32'd0);
    tick(); reset = 1'b0;

    // Three pulses read back in order
    rd_ready = 1'b1;
    pulse(8'h80); pulse(8'h3C); pulse(8'hFF);
    tick();
    chk("three_cnt", 32'(sample_cnt), 32'd3);

    // Held eoc gives one write
    do_reset();
    eoc = 1'b1; data = 8'h55;
    repeat (5) tick();
    eoc = 1'b0; tick();
    chk("hold_level", 32'(level), 32'd1);
    chk("hold_cnt",   32'(sample_cnt), 32'd1);

    // Fill, overflow, drain
    do_reset();
    for (int i = 1; i <= 8; i++) pulse(SW'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ovf",  32'(overflow), 32'd0);
    pulse(8'h09);
    chk("drop_ovf",   32'(overflow), 32'd1);
    chk("drop_cnt",   32'(sample_cnt), 32'd8);
    chk("drop_level", 32'(level), 32'd8);
    rd_ready = 1'b1; repeat (9) tick(); rd_ready = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);

    // Full with simultaneous write and read
    do_reset();
    for (int i = 0; i < 8; i++) pulse(SW'(8'h10 + i));
    eoc = 1'b1; data = 8'hA5; rd_ready = 1'b1; tick();
    eoc = 1'b0; rd_ready = 1'b0; tick();
    chk("rw_full_ovf",   32'(overflow), 32'd0);
    chk("rw_full_level", 32'(level), 32'd8);
    rd_ready = 1'b1; repeat (7) tick();
    chk("rw_last_data", 32'(rd_data), 32'hA5);
    tick(); rd_ready = 1'b0;

    // Drop coinciding with clear
    for (int i = 0; i < 8; i++) pulse(SW'(8'h20 + i));
    eoc = 1'b1; data = 8'hEE; clr_ovf = 1'b1; tick();
    chk("drop_clr_ovf", 32'(overflow), 32'd1);
    eoc = 1'b0; tick();
    chk("clr_ovf", 32'(overflow), 32'd0);
    clr_ovf = 1'b0;

    // Asynchronous reset mid-operation
    do_reset();
    for (int i = 0; i < 5; i++) pulse(SW'(8'h40 + i));
    chk("pre_rst_level", 32'(level), 32'd5);
    reset = 1'b1; #1;
    chk("async_level",    32'(level),    32'd0);
    chk("async_rd_valid", 32'(rd_valid), 32'd0);
    chk("async_empty",    32'(empty),    32'd1);
    tick(); reset = 1'b0;
    pulse(8'h12);
    chk("post_rst_data", 32'(rd_data), 32'h12);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;

    // eoc already high when reset releases
    reset = 1'b1; eoc = 1'b1; data = 8'h77; tick();
    reset = 1'b0; tick();
    chk("eoc_at_release", 32'(level), 32'd1);
    eoc = 1'b0; tick();

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      eoc      = ($urandom_range(0, 2) == 0);
      data     = SW'($urandom);
      rd_ready = ($urandom_range(0, 3) == 0) ? 1'b1 : (c % 200 < 100);
      clr_ovf  = ($urandom_range(0, 15) == 0);
      tick();
    end
    eoc = 1'b0; clr_ovf = 1'b0; rd_ready = 1'b1;
    repeat (12) tick();
    chk("final_empty", 32'(empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
